ll_seizure_detector: RTL and testbench
======================================

Name: ll_seizure_detector

Overview:
Consumer end of the line-length datapath. It reads each windowed line-length value (ll_in/ll_valid) from the LL module and compares it against a runtime threshold. An event is declared after consec_need consecutive exceedances; the event is held until the controller acknowledges it, followed by a refractory hold-off. The block also counts declared events for the host.

Parameters:
ll_width, 25, width of the signed line-length input and the threshold
consec_need, 3, consecutive exceeding valid samples required to declare an event (legal range 1..255)
holdoff_len, 8, valid samples ignored after ack before detection re-arms (legal range 1..255)
evt_width, 8, width of the saturating event counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
en  in  1  active-low enable; when high, all state is frozen and all inputs are ignored
ll_in  in  ll_width  signed line-length value, qualified by ll_valid
ll_valid  in  1  one-cycle strobe; each high cycle is one new sample
thresh  in  ll_width  signed threshold, sampled on the same cycle as ll_valid
ack  in  1  controller acknowledge; clears the held event
evt_flag  out  1  level output, high from event declaration until ack
evt_pulse  out  1  one-cycle pulse on event declaration
evt_count  out  evt_width  number of declared events, saturates at all-ones
busy  out  1  high in ALARM or HOLDOFF

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; run_cnt=0; hold_cnt=0; evt_flag=0; evt_pulse=0; evt_count=0; busy=0. Reset mid-run or mid-alarm discards the run and the alarm without producing a pulse.
- All outputs are registered. evt_pulse defaults to 0 each enabled cycle.
- Exceed test: exceed = (ll_in > thresh), strict and signed. Equality is not an exceedance.
- en=1: no register changes, including evt_pulse, which holds its current value. Hold the strobes low while en=1.
- IDLE: on ll_valid & exceed, run_cnt=1.
  - If consec_need==1, go directly to ALARM.
  - Otherwise go to COUNT.
- COUNT:
  - ll_valid & exceed: run_cnt+1. When run_cnt+1 == consec_need, go to ALARM.
  - ll_valid & !exceed: run_cnt=0, go to IDLE.
  - Cycles without ll_valid do not break the run.
- Entering ALARM: evt_flag=1, evt_pulse=1 for exactly one cycle, evt_count+1 (saturating), busy=1. evt_pulse is high on the cycle after the completing sample's edge (latency 1).
- ALARM: ll_valid samples are ignored. ack=1: evt_flag=0, hold_cnt=0, go to HOLDOFF. An ll_valid on the same cycle as ack is not counted toward hold-off.
- HOLDOFF: each ll_valid increments hold_cnt. When hold_cnt+1 == holdoff_len, go to IDLE with run_cnt=0 and busy=0. A sample that ends hold-off is not evaluated for exceedance.
- ack outside ALARM is ignored.
- ack on the same cycle the ALARM is entered (the completing sample's cycle) is ignored; ack must arrive in ALARM.
- evt_count at all-ones stays at all-ones; evt_flag and evt_pulse still operate.

Optional Feature:
LL_SEIZURE_DETECTOR_PEAK_EN.
- Defined: adds output peak_ll [ll_width-1:0], signed and registered.
  - Loads ll_in on the first exceeding sample of a run in IDLE.
  - Updates to max(peak_ll, ll_in) on every exceeding sample in COUNT and ALARM.
  - Frozen in HOLDOFF; reset to 0.
  - A run break in COUNT does not clear peak_ll; the next run start reloads it.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. thresh=1000, ll_in=1001,1002,1003 on three ll_valid strobes -> evt_pulse high one cycle after the third sample; evt_flag=1; evt_count=1; busy=1.
2. thresh=1000, ll_in=1001,1000,1001,1001 -> no event (equality breaks the run); one more ll_in=1001 -> event declared.
3. After an event, assert ack with 8 ll_valid samples of 5000 -> evt_flag=0 immediately after ack; no new event during those 8; busy drops after the 8th; three more 5000 samples -> evt_count=2.
4. Reset with rst=0 while in COUNT with run_cnt=2, then a single sample 5000 -> no event; all outputs 0 after reset.
5. en=1 during three exceeding strobes -> no state change; en=0 followed by three strobes -> event. Ack held during IDLE -> ignored.
6. evt_width=2, four acked events -> evt_count=3 (saturated), evt_pulse still fires on the fourth. With PEAK_EN, samples 1200,1500,1300 -> peak_ll=1500.

Source files
------------

// File: rtl/ll_seizure_detector_if.sv
// ----------------------------------------------------------------------------
// ll_seizure_detector_if
// Bundles the sample stream, threshold, acknowledge and event outputs of the
// line-length seizure detector.
//   ll_in     signed line-length sample, qualified by ll_valid
//   ll_valid  one-cycle sample strobe
//   thresh    signed threshold, sampled together with ll_valid
//   ack       controller acknowledge of a held event
//   evt_flag  level, high from event declaration until ack
//   evt_pulse one-cycle pulse on event declaration
//   evt_count saturating count of declared events
//   busy      high while the detector is in ALARM or HOLDOFF
//   peak_ll   (only with LL_SEIZURE_DETECTOR_PEAK_EN) peak exceeding sample
// Modports: master = controller/LL side, slave = detector.
// Optional feature macro: LL_SEIZURE_DETECTOR_PEAK_EN
// ----------------------------------------------------------------------------
interface ll_seizure_detector_if #(
    parameter int ll_width  = 25,
    parameter int evt_width = 8
);
    logic signed [ll_width-1:0] ll_in;
    logic                       ll_valid;
    logic signed [ll_width-1:0] thresh;
    logic                       ack;
    logic                       evt_flag;
    logic                       evt_pulse;
    logic        [evt_width-1:0] evt_count;
    logic                       busy;
`ifdef LL_SEIZURE_DETECTOR_PEAK_EN
    logic signed [ll_width-1:0] peak_ll;

    modport master (
        output ll_in, ll_valid, thresh, ack,
        input  evt_flag, evt_pulse, evt_count, busy, peak_ll
    );
    modport slave (
        input  ll_in, ll_valid, thresh, ack,
        output evt_flag, evt_pulse, evt_count, busy, peak_ll
    );
`else
    modport master (
        output ll_in, ll_valid, thresh, ack,
        input  evt_flag, evt_pulse, evt_count, busy
    );
    modport slave (
        input  ll_in, ll_valid, thresh, ack,
        output evt_flag, evt_pulse, evt_count, busy
    );
`endif
endinterface

// File: rtl/ll_seizure_detector.sv
// ----------------------------------------------------------------------------
// ll_seizure_detector
// Compares each windowed line-length sample against a runtime threshold and
// declares an event after consec_need consecutive exceedances. The event is
// held until acknowledged, then holdoff_len valid samples are ignored before
// detection re-arms. Declared events are counted (saturating).
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active-low
//   en   active-low enable; high freezes every register
//   bus  ll_seizure_detector_if.slave (samples, threshold, ack, event outputs)
// Optional feature macro: LL_SEIZURE_DETECTOR_PEAK_EN adds bus.peak_ll, the
// largest exceeding sample of the current/last run.
// ----------------------------------------------------------------------------
module ll_seizure_detector #(
    parameter int ll_width    = 25,
    parameter int consec_need = 3,
    parameter int holdoff_len = 8,
    parameter int evt_width   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    ll_seizure_detector_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COUNT, ALARM, HOLDOFF} state_t;

    localparam logic [7:0] CONSEC_NEED = 8'(consec_need);
    localparam logic [7:0] HOLDOFF_LEN = 8'(holdoff_len);

    state_t                state_q, state_d;
    logic [7:0]            run_cnt_q, run_cnt_d;
    logic [7:0]            hold_cnt_q, hold_cnt_d;
    logic                  evt_flag_q, evt_flag_d;
    logic                  evt_pulse_q, evt_pulse_d;
    logic                  busy_q, busy_d;
    logic [evt_width-1:0]  evt_count_q, evt_count_d;
`ifdef LL_SEIZURE_DETECTOR_PEAK_EN
    logic signed [ll_width-1:0] peak_q, peak_d;
`endif

    logic exceed;
    logic declare_evt;

    // Strict signed comparison: equality does not count as an exceedance.
    assign exceed = $signed(bus.ll_in) > $signed(bus.thresh);

    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can leave a
        // signal unassigned and infer a latch.
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        evt_flag_d  = evt_flag_q;
        evt_pulse_d = evt_pulse_q;
        busy_d      = busy_q;
        evt_count_d = evt_count_q;
        declare_evt = 1'b0;
`ifdef LL_SEIZURE_DETECTOR_PEAK_EN
        peak_d      = peak_q;
`endif
        // en high freezes everything, including a pulse already on the output.
        if (!en) begin
            evt_pulse_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.ll_valid && exceed) begin
                        run_cnt_d = 8'd1;
`ifdef LL_SEIZURE_DETECTOR_PEAK_EN
                        peak_d    = bus.ll_in;
`endif
                        if (CONSEC_NEED == 8'd1) declare_evt = 1'b1;
                        else                     state_d     = COUNT;
                    end
                end
                COUNT: begin
                    // Cycles without ll_valid leave the run intact.
                    if (bus.ll_valid) begin
                        if (exceed) begin
                            run_cnt_d = run_cnt_q + 8'd1;
`ifdef LL_SEIZURE_DETECTOR_PEAK_EN
                            if (bus.ll_in > peak_q) peak_d = bus.ll_in;
`endif
                            if (run_cnt_q + 8'd1 == CONSEC_NEED) declare_evt = 1'b1;
                        end else begin
                            run_cnt_d = 8'd0;
                            state_d   = IDLE;
                        end
                    end
                end
                ALARM: begin
`ifdef LL_SEIZURE_DETECTOR_PEAK_EN
                    if (bus.ll_valid && exceed && (bus.ll_in > peak_q)) peak_d = bus.ll_in;
`endif
                    // A sample arriving with ack is not part of the hold-off.
                    if (bus.ack) begin
                        evt_flag_d = 1'b0;
                        hold_cnt_d = 8'd0;
                        state_d    = HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (bus.ll_valid) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                        // The sample that ends hold-off is consumed, not tested.
                        if (hold_cnt_q + 8'd1 == HOLDOFF_LEN) begin
                            state_d   = IDLE;
                            run_cnt_d = 8'd0;
                            busy_d    = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (declare_evt) begin
                state_d     = ALARM;
                evt_flag_d  = 1'b1;
                evt_pulse_d = 1'b1;
                busy_d      = 1'b1;
                if (evt_count_q != '1) evt_count_d = evt_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // the pre-edge value of its inputs regardless of statement order.
        if (!rst) begin
            state_q     <= IDLE;
            run_cnt_q   <= 8'd0;
            hold_cnt_q  <= 8'd0;
            evt_flag_q  <= 1'b0;
            evt_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
            evt_count_q <= '0;
`ifdef LL_SEIZURE_DETECTOR_PEAK_EN
            peak_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            evt_flag_q  <= evt_flag_d;
            evt_pulse_q <= evt_pulse_d;
            busy_q      <= busy_d;
            evt_count_q <= evt_count_d;
`ifdef LL_SEIZURE_DETECTOR_PEAK_EN
            peak_q      <= peak_d;
`endif
        end
    end

    assign bus.evt_flag  = evt_flag_q;
    assign bus.evt_pulse = evt_pulse_q;
    assign bus.evt_count = evt_count_q;
    assign bus.busy      = busy_q;
`ifdef LL_SEIZURE_DETECTOR_PEAK_EN
    assign bus.peak_ll   = peak_q;
`endif

endmodule

// File: tb/tb_ll_seizure_detector.sv
// ----------------------------------------------------------------------------
// tb_ll_seizure_detector
// Table-driven bench for ll_seizure_detector (consec_need=3, holdoff_len=8,
// evt_width=2 so counter saturation is reachable). Each step drives inputs on
// the falling edge, queues the expected post-edge outputs, and compares them
// 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_ll_seizure_detector;
    localparam int LLW = 25;
    localparam int EW  = 2;
    localparam int TH  = 1000;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    ll_seizure_detector_if #(.ll_width(LLW), .evt_width(EW)) bus ();

    ll_seizure_detector #(
        .ll_width(LLW), .consec_need(3), .holdoff_len(8), .evt_width(EW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en (en),
        .bus(bus)
    );

    typedef struct {
        logic                   rst_v;
        logic                   en_v;
        logic                   valid;
        logic signed [LLW-1:0]  ll;
        logic signed [LLW-1:0]  th;
        logic                   ack;
        logic                   flag;
        logic                   pulse;
        logic [EW-1:0]          cnt;
        logic                   busy;
    } vec_t;

    typedef struct {
        logic          flag;
        logic          pulse;
        logic [EW-1:0] cnt;
        logic          busy;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input bit r, input bit e, input bit v, input int ll,
                                input int th, input bit a, input bit f, input bit p,
                                input int c, input bit b);
        vec_t x;
        x.rst_v = r;  x.en_v = e;  x.valid = v;
        x.ll    = LLW'(ll);
        x.th    = LLW'(th);
        x.ack   = a;  x.flag = f;  x.pulse = p;
        x.cnt   = c[EW-1:0];
        x.busy  = b;
        return x;
    endfunction

    task automatic add(input bit r, input bit e, input bit v, input int ll, input bit a,
                       input bit f, input bit p, input int c, input bit b);
        vecs.push_back(mk(r, e, v, ll, TH, a, f, p, c, b));
    endtask

    // Ack a held event, then feed 8 below-threshold samples; busy drops on the 8th.
    task automatic add_release(input int c);
        add(1, 0, 0, 0, 1, 0, 0, c, 1);
        for (int k = 0; k < 7; k++) add(1, 0, 1, 0, 0, 0, 0, c, 1);
        add(1, 0, 1, 0, 0, 0, 0, c, 0);
    endtask

    task automatic step(input vec_t v, input string tag, input int idx);
        exp_t e;
        @(negedge clk);
        rst          = v.rst_v;
        en           = v.en_v;
        bus.ll_valid = v.valid;
        bus.ll_in    = v.ll;
        bus.thresh   = v.th;
        bus.ack      = v.ack;
        exp_q.push_back('{flag: v.flag, pulse: v.pulse, cnt: v.cnt, busy: v.busy});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s[%0d] scoreboard empty", tag, idx);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("%s[%0d] evt_flag", tag, idx),  int'(bus.evt_flag),  int'(e.flag));
            check($sformatf("%s[%0d] evt_pulse", tag, idx), int'(bus.evt_pulse), int'(e.pulse));
            check($sformatf("%s[%0d] evt_count", tag, idx), int'(bus.evt_count), int'(e.cnt));
            check($sformatf("%s[%0d] busy", tag, idx),      int'(bus.busy),      int'(e.busy));
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0;
        bus.ll_valid = 1'b0; bus.ll_in = '0; bus.thresh = LLW'(TH); bus.ack = 1'b0;

        // Reset state
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Three exceeding samples declare an event with latency 1
        add(1, 0, 1, 1001, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1002, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1003, 0, 1, 1, 1, 1);
        add(1, 0, 0, 0,    0, 1, 0, 1, 1);
        // Ack with a same-cycle sample (not counted), then 8 hold-off samples
        add(1, 0, 1, 5000, 1, 0, 0, 1, 1);
        for (int k = 0; k < 7; k++) add(1, 0, 1, 5000, 0, 0, 0, 1, 1);
        add(1, 0, 1, 5000, 0, 0, 0, 1, 0);
        add(1, 0, 1, 5000, 0, 0, 0, 1, 0);
        add(1, 0, 1, 5000, 0, 0, 0, 1, 0);
        add(1, 0, 1, 5000, 0, 1, 1, 2, 1);
        add_release(2);
        // Equality breaks a run; a gap without ll_valid does not
        add(1, 0, 1, 1001, 0, 0, 0, 2, 0);
        add(1, 0, 1, 1000, 0, 0, 0, 2, 0);
        add(1, 0, 1, 1001, 0, 0, 0, 2, 0);
        add(1, 0, 1, 1001, 0, 0, 0, 2, 0);
        add(1, 0, 0, 0,    0, 0, 0, 2, 0);
        add(1, 0, 1, 1001, 0, 1, 1, 3, 1);
        add_release(3);
        // Reset mid-run discards the run and clears the counter
        add(1, 0, 1, 1001, 0, 0, 0, 3, 0);
        add(1, 0, 1, 1001, 0, 0, 0, 3, 0);
        add(0, 0, 0, 0,    0, 0, 0, 0, 0);
        add(1, 0, 1, 5000, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0,    0, 0, 0, 0, 0);
        add(1, 0, 1, 5000, 0, 0, 0, 0, 0);
        add(1, 0, 1, 5000, 0, 1, 1, 1, 1);
        // en high freezes a pulse that is already asserted
        add(1, 1, 0, 0,    0, 1, 1, 1, 1);
        add(1, 0, 0, 0,    0, 1, 0, 1, 1);
        add_release(1);
        // Strobes while disabled are ignored; ack in IDLE is ignored
        add(1, 1, 1, 5000, 0, 0, 0, 1, 0);
        add(1, 1, 1, 5000, 0, 0, 0, 1, 0);
        add(1, 1, 1, 5000, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0,    1, 0, 0, 1, 0);
        add(1, 0, 1, 5000, 0, 0, 0, 1, 0);
        add(1, 0, 1, 5000, 0, 0, 0, 1, 0);
        // Ack on the completing sample's cycle is ignored: flag stays up
        add(1, 0, 1, 5000, 1, 1, 1, 2, 1);
        add(1, 0, 0, 0,    0, 1, 0, 2, 1);
        add_release(2);
        // Signed compare: 2 > -5 is an exceedance
        vecs.push_back(mk(1, 0, 1, 2, -5, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 1, 2, -5, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 1, 2, -5, 0, 1, 1, 3, 1));
        add_release(3);

        foreach (vecs[i]) step(vecs[i], "tbl", i);

        // Fourth acked event since reset: counter stays saturated, pulse fires
        step(mk(1, 0, 1, 5000, TH, 0, 0, 0, 3, 0), "sat", 0);
        step(mk(1, 0, 1, 5000, TH, 0, 0, 0, 3, 0), "sat", 1);
        step(mk(1, 0, 1, 5000, TH, 0, 1, 1, 3, 1), "sat", 2);
        step(mk(1, 0, 0, 0,    TH, 0, 1, 0, 3, 1), "sat", 3);

`ifdef LL_SEIZURE_DETECTOR_PEAK_EN
        step(mk(1, 0, 0, 0, TH, 1, 0, 0, 3, 1), "pk", 0);
        for (int k = 0; k < 7; k++) step(mk(1, 0, 1, 0, TH, 0, 0, 0, 3, 1), "pk", 1 + k);
        step(mk(1, 0, 1, 0,    TH, 0, 0, 0, 3, 0), "pk", 8);
        step(mk(1, 0, 1, 2000, TH, 0, 0, 0, 3, 0), "pk", 9);
        step(mk(1, 0, 1, 500,  TH, 0, 0, 0, 3, 0), "pk", 10);
        check("peak after run break", int'(bus.peak_ll), 2000);
        step(mk(1, 0, 1, 1200, TH, 0, 0, 0, 3, 0), "pk", 11);
        check("peak reload on run start", int'(bus.peak_ll), 1200);
        step(mk(1, 0, 1, 1500, TH, 0, 0, 0, 3, 0), "pk", 12);
        step(mk(1, 0, 1, 1300, TH, 0, 1, 1, 3, 1), "pk", 13);
        check("peak max of run", int'(bus.peak_ll), 1500);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
